mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressed, big-endian, 32-bit-word data memory.
- Shares the memory between an instruction-fetch requester (read-only) and a data requester (read/write).
- Drives the memory's adr/writedata/memread/memwrite for a fixed number of cycles, captures read data, and returns a one-cycle acknowledge to the granted requester.
- Sits between the multicycle core's fetch/load-store units and the data memory.

Parameters:
- LATENCY, 2, cycles the memory controls are held per access (>=1)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- i_req  input  1  fetch request; held until i_ack
- i_adr  input  ADDR_W  fetch byte address
- i_rdata  output  DATA_W  fetch read data; valid with i_ack, held until next fetch completion
- i_ack  output  1  one-cycle fetch completion pulse
- d_req  input  1  data request; held until d_ack
- d_we  input  1  1 = write, 0 = read
- d_adr  input  ADDR_W  data byte address
- d_wdata  input  DATA_W  write data
- d_rdata  output  DATA_W  data read result; valid with d_ack
- d_ack  output  1  one-cycle data completion pulse
- d_err  output  1  misaligned data access; pulses with d_ack
- mem_adr  output  ADDR_W  to memory adr
- mem_writedata  output  DATA_W  to memory writedata
- mem_read  output  1  to memory memread
- mem_write  output  1  to memory memwrite
- mem_data  input  DATA_W  from memory data
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all outputs and registers clear to 0.
  - Round-robin pointer is set so the data port wins the first tie.
  - An in-flight access is abandoned: no ack and no memory write.
- States: IDLE, ACCESS, DONE. All outputs are registered or decoded from state/registers; there is no combinational path from req to mem_*.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port NOT granted most recently. The pointer updates at each grant.
  - At the grant edge, latch adr, we (fetch grant forces we=0), wdata and the granted port ID. Load cnt = LATENCY-1.
  - Go to ACCESS, except a data grant with d_adr[1:0] != 0, which goes directly to DONE with err set and performs no memory access.
- ACCESS:
  - mem_adr and mem_writedata come from the latched registers.
  - mem_read = ~we for every ACCESS cycle.
  - mem_write = we only in the ACCESS cycle with cnt==0, so memory is written exactly once.
  - cnt decrements each cycle.
  - At the edge leaving cnt==0: if read, capture mem_data into the granted port's rdata register; then go to DONE.
- DONE:
  - Granted port's ack = 1 for exactly this cycle; d_err = err for a data grant.
  - mem_read and mem_write are 0.
  - Next edge goes to IDLE and clears err.
- Timing:
  - Access latency is LATENCY+1 cycles from the grant edge to the ack-high cycle.
  - Minimum spacing between grants is LATENCY+2 cycles.
  - A req still high in the DONE cycle is treated as a new request in the following IDLE cycle. Requesters must drop req in the ack cycle to avoid a repeat.
- Request dropped mid-access: the transaction still completes and ack still pulses.
- Request inputs changing after the grant have no effect (all fields are latched at the grant edge).
- rdata registers of the non-granted port are unchanged. A write access leaves d_rdata unchanged.
- Addresses pass through unmodified. Byte ordering is owned by the memory.

Test Plan:
- Single fetch, LATENCY=2, memory word at 0x10 = 0xDEADBEEF, i_req with i_adr=0x10 → mem_read high for 2 cycles, i_ack high 3 cycles after the grant edge, i_rdata=0xDEADBEEF, busy low afterwards.
- Data write d_adr=0x20, d_wdata=0x12345678, then data read 0x20 → mem_write high exactly one cycle; the read returns d_rdata=0x12345678 with d_ack.
- i_req and d_req both held for 3 transactions each → grant order D, I, D, I, D, I after reset; no ack is ever given to the wrong port; every ack is one cycle wide.
- Misaligned data read d_adr=0x22 → d_ack and d_err high together 1 cycle after the grant, mem_read/mem_write never asserted, d_rdata unchanged.
- Assert reset (low) during the second ACCESS cycle of a write to 0x30 → outputs 0 immediately, no ack, memory at 0x30 unchanged, the next request is serviced normally after reset releases.
- i_req dropped during ACCESS → i_ack still pulses once; no second fetch is issued.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the two-port memory arbiter.
// The slave modport is the arbiter; master is the requesters plus the memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Instruction-fetch port (read-only)
    logic              i_req;
    logic [ADDR_W-1:0] i_adr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    // Data port (read/write)
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_err;

    // Data memory controls
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_data,
        output i_rdata, i_ack, d_rdata, d_ack, d_err,
               mem_adr, mem_writedata, mem_read, mem_write
    );

    modport master (
        output i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_data,
        input  i_rdata, i_ack, d_rdata, d_ack, d_err,
               mem_adr, mem_writedata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one data memory between
// the fetch port and the load/store port. Every output is a flop.
module mem_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus,
    output logic           busy
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [ADDR_W-1:0]  adr_q, adr_n;
    logic [DATA_W-1:0]  wdata_q, wdata_n;
    logic               we_q, we_n;
    logic               port_q, port_n;
    logic               err_q, err_n;
    logic               prio_i_q, prio_i_n;   // 1: fetch wins the next tie
    logic [DATA_W-1:0]  i_rdata_q, i_rdata_n;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_n;
    logic               i_ack_q, i_ack_n;
    logic               d_ack_q, d_ack_n;
    logic               d_err_q, d_err_n;
    logic               mem_read_q, mem_read_n;
    logic               mem_write_q, mem_write_n;
    logic               busy_q, busy_n;
    logic               grant_i;

    // State, latched transaction fields and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            adr_q       <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            port_q      <= PORT_D;
            err_q       <= 1'b0;
            prio_i_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            adr_q       <= adr_n;
            wdata_q     <= wdata_n;
            we_q        <= we_n;
            port_q      <= port_n;
            err_q       <= err_n;
            prio_i_q    <= prio_i_n;
            i_rdata_q   <= i_rdata_n;
            d_rdata_q   <= d_rdata_n;
            i_ack_q     <= i_ack_n;
            d_ack_q     <= d_ack_n;
            d_err_q     <= d_err_n;
            mem_read_q  <= mem_read_n;
            mem_write_q <= mem_write_n;
            busy_q      <= busy_n;
        end
    end

    // Next state, grant decision, read capture and next output values
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        adr_n     = adr_q;
        wdata_n   = wdata_q;
        we_n      = we_q;
        port_n    = port_q;
        err_n     = err_q;
        prio_i_n  = prio_i_q;
        i_rdata_n = i_rdata_q;
        d_rdata_n = d_rdata_q;
        grant_i   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    grant_i  = bus.i_req && (!bus.d_req || prio_i_q);
                    port_n   = grant_i ? PORT_I : PORT_D;
                    prio_i_n = !grant_i;
                    adr_n    = grant_i ? bus.i_adr : bus.d_adr;
                    wdata_n  = bus.d_wdata;
                    we_n     = !grant_i && bus.d_we;
                    cnt_n    = CNT_W'(LATENCY - 1);
                    // Misaligned data access never touches memory
                    if (!grant_i && (bus.d_adr[1:0] != 2'b00)) begin
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (port_q == PORT_I) begin
                            i_rdata_n = bus.mem_data;
                        end else begin
                            d_rdata_n = bus.mem_data;
                        end
                    end
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            DONE: begin
                err_n   = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        i_ack_n     = (state_n == DONE) && (port_n == PORT_I);
        d_ack_n     = (state_n == DONE) && (port_n == PORT_D);
        d_err_n     = d_ack_n && err_n;
        mem_read_n  = (state_n == ACCESS) && !we_n;
        mem_write_n = (state_n == ACCESS) && we_n && (cnt_n == '0);
        busy_n      = (state_n != IDLE);
    end

    assign bus.i_rdata       = i_rdata_q;
    assign bus.i_ack         = i_ack_q;
    assign bus.d_rdata       = d_rdata_q;
    assign bus.d_ack         = d_ack_q;
    assign bus.d_err         = d_err_q;
    assign bus.mem_adr       = adr_q;
    assign bus.mem_writedata = wdata_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign busy              = busy_q;

endmodule
